// File: rtl/via_pkg.sv
// ---------------------------------------------------------------------------
// via_pkg : shared register map, bit indices and helpers for the VIA timers
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package via_pkg;

   typedef logic [3:0] reg_off_t;

   localparam reg_off_t REG_T1CL = 4'h4;
   localparam reg_off_t REG_T1CH = 4'h5;
   localparam reg_off_t REG_T1LL = 4'h6;
   localparam reg_off_t REG_T1LH = 4'h7;
   localparam reg_off_t REG_T2CL = 4'h8;
   localparam reg_off_t REG_T2CH = 4'h9;
   localparam reg_off_t REG_ACR  = 4'hB;
   localparam reg_off_t REG_IFR  = 4'hD;
   localparam reg_off_t REG_IER  = 4'hE;

   localparam int IFR_T2  = 5;
   localparam int IFR_T1  = 6;
   localparam int IFR_ANY = 7;

   localparam int ACR_T2_PULSE   = 5;
   localparam int ACR_T1_FREERUN = 6;
   localparam int ACR_T1_PB7     = 7;

   function automatic logic irq_pending(input logic [6:0] ifr, input logic [6:0] ier);
      return |(ifr & ier);
   endfunction

endpackage : via_pkg

`default_nettype wire

// File: rtl/via_timer16.sv
// ---------------------------------------------------------------------------
// via_timer16 : 16-bit VIA down-counter with load, arm and underflow pulse
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module via_timer16 #(
   parameter bit FREERUN_CAPABLE = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_i,
   input  logic [15:0] load_val_i,
   input  logic        tick_i,
   input  logic        freerun_i,
   input  logic [15:0] reload_val_i,
   output logic [15:0] cnt_o,
   output logic        uflow_o
);

   logic [15:0] cnt_q, cnt_d;
   logic        armed_q, armed_d;
   logic        w_freerun;

   generate
      if (FREERUN_CAPABLE) begin : g_freerun
         assign w_freerun = freerun_i;
      end else begin : g_oneshot
         logic w_unused;
         assign w_freerun = 1'b0;
         assign w_unused  = ^{freerun_i, reload_val_i};
      end
   endgenerate

   // A load in the same cycle as a tick wins: no decrement, no underflow.
   always_comb begin
      cnt_d   = cnt_q;
      armed_d = armed_q;
      uflow_o = 1'b0;
      if (load_i) begin
         cnt_d   = load_val_i;
         armed_d = 1'b1;
      end else if (tick_i) begin
         if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
         end else if (armed_q) begin
            uflow_o = 1'b1;
            if (w_freerun) begin
               cnt_d = reload_val_i;
            end else begin
               cnt_d   = 16'hFFFF;
               armed_d = 1'b0;
            end
         end else begin
            cnt_d = 16'hFFFF;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= 16'hFFFF;
         armed_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule : via_timer16

`default_nettype wire

// File: rtl/via_timer_irq_ctrl.sv
// ---------------------------------------------------------------------------
// via_timer_irq_ctrl : VIA T1/T2 sequencing, ACR/IFR/IER and CPU IRQ
// Optional macro VIA_T2_PULSECOUNT_EN: T2 counts PB6 falling edges when ACR[5]=1
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module via_timer_irq_ctrl
   import via_pkg::*;
#(
   parameter int PHI2_SYNC = 1
) (
   input  logic       clk6x,
   input  logic       resetn,
   input  logic [3:0] slv_addr_i,
   input  logic [7:0] slv_datawr_i,
   input  logic       slv_datawr_valid,
   input  logic       slv_req_i,
   input  logic       slv_rwn_i,
   output logic [7:0] slv_datard_o,
   input  logic       phi2,
   input  logic       pb6_i,
   output logic       pb7_o,
   output logic       pb7_en_o,
   output logic       irqn_o
);

   logic       w_phi2_s;
   logic       phi2_prev_q;
   logic       phi2_seen_q;
   logic       w_phi2_fall;
   logic       w_tick;
   logic       w_t2_tick;

   logic       rd_cond_q, wr_cond_q;
   logic       w_rd_cond, w_wr_cond, w_rd_stb, w_wr_stb;

   logic [7:0] t1_latch_lo_q, t1_latch_lo_d;
   logic [7:0] t1_latch_hi_q, t1_latch_hi_d;
   logic [7:0] t2_latch_lo_q, t2_latch_lo_d;
   logic [7:0] acr_q, acr_d;
   logic [6:0] ier_q, ier_d;
   logic       ifr_t1_q, ifr_t1_d;
   logic       ifr_t2_q, ifr_t2_d;
   logic       pb7_q, pb7_d;
   logic [7:0] datard_q;
   logic       irqn_q;

   logic       w_t1_load, w_t2_load;
   logic       w_t1_uflow, w_t2_uflow;
   logic [15:0] w_t1_cnt, w_t2_cnt;
   logic [6:0] w_ifr;
   logic [7:0] w_rd_data;

   generate
      if (PHI2_SYNC != 0) begin : g_phi2_sync
         logic [1:0] sync_q;
         always_ff @(posedge clk6x or negedge resetn) begin
            if (!resetn) sync_q <= 2'b00;
            else         sync_q <= {sync_q[0], phi2};
         end
         assign w_phi2_s = sync_q[1];
      end else begin : g_phi2_direct
         assign w_phi2_s = phi2;
      end
   endgenerate

   // The detector history resets low, so the first fall seen after reset only
   // primes phi2_seen_q and produces no tick.
   assign w_phi2_fall = phi2_prev_q & ~w_phi2_s;
   assign w_tick      = w_phi2_fall & phi2_seen_q;

   always_ff @(posedge clk6x or negedge resetn) begin
      if (!resetn) begin
         phi2_prev_q <= 1'b0;
         phi2_seen_q <= 1'b0;
      end else begin
         phi2_prev_q <= w_phi2_s;
         if (w_phi2_fall) phi2_seen_q <= 1'b1;
      end
   end

`ifdef VIA_T2_PULSECOUNT_EN
   logic [1:0] pb6_sync_q;
   logic       pb6_prev_q;
   logic       w_pb6_fall;

   always_ff @(posedge clk6x or negedge resetn) begin
      if (!resetn) begin
         pb6_sync_q <= 2'b00;
         pb6_prev_q <= 1'b0;
      end else begin
         pb6_sync_q <= {pb6_sync_q[0], pb6_i};
         pb6_prev_q <= pb6_sync_q[1];
      end
   end

   assign w_pb6_fall = pb6_prev_q & ~pb6_sync_q[1];
   assign w_t2_tick  = acr_q[ACR_T2_PULSE] ? w_pb6_fall : w_tick;
`else
   logic w_unused_pb6;
   assign w_unused_pb6 = pb6_i;
   assign w_t2_tick    = w_tick;
`endif

   // Accesses act once, on the first cycle of a request.
   assign w_rd_cond = slv_req_i & slv_rwn_i;
   assign w_wr_cond = slv_req_i & ~slv_rwn_i & slv_datawr_valid;
   assign w_rd_stb  = w_rd_cond & ~rd_cond_q;
   assign w_wr_stb  = w_wr_cond & ~wr_cond_q;

   assign w_t1_load = w_wr_stb & (slv_addr_i == REG_T1CH);
   assign w_t2_load = w_wr_stb & (slv_addr_i == REG_T2CH);

   via_timer16 #(
      .FREERUN_CAPABLE (1'b1)
   ) u_t1 (
      .clk          (clk6x),
      .rst_n        (resetn),
      .load_i       (w_t1_load),
      .load_val_i   ({slv_datawr_i, t1_latch_lo_q}),
      .tick_i       (w_tick),
      .freerun_i    (acr_q[ACR_T1_FREERUN]),
      .reload_val_i ({t1_latch_hi_q, t1_latch_lo_q}),
      .cnt_o        (w_t1_cnt),
      .uflow_o      (w_t1_uflow)
   );

   via_timer16 #(
      .FREERUN_CAPABLE (1'b0)
   ) u_t2 (
      .clk          (clk6x),
      .rst_n        (resetn),
      .load_i       (w_t2_load),
      .load_val_i   ({slv_datawr_i, t2_latch_lo_q}),
      .tick_i       (w_t2_tick),
      .freerun_i    (1'b0),
      .reload_val_i (16'h0000),
      .cnt_o        (w_t2_cnt),
      .uflow_o      (w_t2_uflow)
   );

   // Bus clears are applied first so a same-cycle underflow flag overrides them.
   always_comb begin
      t1_latch_lo_d = t1_latch_lo_q;
      t1_latch_hi_d = t1_latch_hi_q;
      t2_latch_lo_d = t2_latch_lo_q;
      acr_d         = acr_q;
      ier_d         = ier_q;
      ifr_t1_d      = ifr_t1_q;
      ifr_t2_d      = ifr_t2_q;
      pb7_d         = pb7_q;

      if (w_wr_stb) begin
         case (slv_addr_i)
            REG_T1CL, REG_T1LL: t1_latch_lo_d = slv_datawr_i;
            REG_T1CH: begin
               t1_latch_hi_d = slv_datawr_i;
               ifr_t1_d      = 1'b0;
               if (acr_q[ACR_T1_PB7]) pb7_d = 1'b0;
            end
            REG_T1LH: begin
               t1_latch_hi_d = slv_datawr_i;
               ifr_t1_d      = 1'b0;
            end
            REG_T2CL: t2_latch_lo_d = slv_datawr_i;
            REG_T2CH: ifr_t2_d = 1'b0;
            REG_ACR:  acr_d = slv_datawr_i;
            REG_IFR: begin
               if (slv_datawr_i[IFR_T1]) ifr_t1_d = 1'b0;
               if (slv_datawr_i[IFR_T2]) ifr_t2_d = 1'b0;
            end
            REG_IER: begin
               if (slv_datawr_i[7]) ier_d = ier_q | slv_datawr_i[6:0];
               else                 ier_d = ier_q & ~slv_datawr_i[6:0];
            end
            default: ;
         endcase
      end

      if (w_rd_stb) begin
         if (slv_addr_i == REG_T1CL) ifr_t1_d = 1'b0;
         if (slv_addr_i == REG_T2CL) ifr_t2_d = 1'b0;
      end

      if (w_t1_uflow) begin
         ifr_t1_d = 1'b1;
         pb7_d    = acr_q[ACR_T1_FREERUN] ? ~pb7_q : 1'b1;
      end
      if (w_t2_uflow) ifr_t2_d = 1'b1;
   end

   assign w_ifr = {ifr_t1_q, ifr_t2_q, 5'b00000};

   always_comb begin
      w_rd_data = 8'h00;
      case (slv_addr_i)
         REG_T1CL: w_rd_data = w_t1_cnt[7:0];
         REG_T1CH: w_rd_data = w_t1_cnt[15:8];
         REG_T1LL: w_rd_data = t1_latch_lo_q;
         REG_T1LH: w_rd_data = t1_latch_hi_q;
         REG_T2CL: w_rd_data = w_t2_cnt[7:0];
         REG_T2CH: w_rd_data = w_t2_cnt[15:8];
         REG_ACR:  w_rd_data = acr_q;
         REG_IFR: begin
            w_rd_data[6:0]   = w_ifr;
            w_rd_data[IFR_ANY] = irq_pending(w_ifr, ier_q);
         end
         REG_IER:  w_rd_data = {1'b1, ier_q};
         default:  w_rd_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk6x or negedge resetn) begin
      if (!resetn) begin
         rd_cond_q     <= 1'b0;
         wr_cond_q     <= 1'b0;
         t1_latch_lo_q <= 8'hFF;
         t1_latch_hi_q <= 8'hFF;
         t2_latch_lo_q <= 8'hFF;
         acr_q         <= 8'h00;
         ier_q         <= 7'h00;
         ifr_t1_q      <= 1'b0;
         ifr_t2_q      <= 1'b0;
         pb7_q         <= 1'b1;
         datard_q      <= 8'h00;
         irqn_q        <= 1'b1;
      end else begin
         rd_cond_q     <= w_rd_cond;
         wr_cond_q     <= w_wr_cond;
         t1_latch_lo_q <= t1_latch_lo_d;
         t1_latch_hi_q <= t1_latch_hi_d;
         t2_latch_lo_q <= t2_latch_lo_d;
         acr_q         <= acr_d;
         ier_q         <= ier_d;
         ifr_t1_q      <= ifr_t1_d;
         ifr_t2_q      <= ifr_t2_d;
         pb7_q         <= pb7_d;
         if (w_rd_cond) datard_q <= w_rd_data;
         irqn_q        <= ~irq_pending(w_ifr, ier_q);
      end
   end

   assign slv_datard_o = datard_q;
   assign pb7_o        = pb7_q;
   assign pb7_en_o     = acr_q[ACR_T1_PB7];
   assign irqn_o       = irqn_q;

endmodule : via_timer_irq_ctrl

`default_nettype wire

// File: doc/via_timer_irq_ctrl.md
Name: via_timer_irq_ctrl

Overview:
- Timer and interrupt controller for the simplified 65C22 VIA.
- Sequences Timer 1 and Timer 2 from the CPU phi2 clock and owns ACR, IFR and IER.
- Drives the CPU IRQ line.
- Sits on the NORA slave bus beside the GPIO register block. The top-level decoder routes VIA offsets 4..9, B, D and E here and muxes slv_datard_o.

Parameters:
- PHI2_SYNC, 1, 1 = 2-FF synchronizer on phi2 before edge detect; 0 = phi2 already clk6x-synchronous (1 FF for edge detect only).

Ports:
- clk6x  in  1  48 MHz system clock.
- resetn  in  1  asynchronous active-low reset.
- slv_addr_i  in  4  VIA register offset.
- slv_datawr_i  in  8  write data.
- slv_datawr_valid  in  1  write data valid.
- slv_req_i  in  1  slave select.
- slv_rwn_i  in  1  1 = read, 0 = write.
- slv_datard_o  out  8  read data (registered).
- phi2  in  1  CPU phase-2 clock.
- pb6_i  in  1  PB6 pin for T2 pulse counting.
- pb7_o  out  1  T1 PB7 output level.
- pb7_en_o  out  1  PB7 output enable (= ACR[7]).
- irqn_o  out  1  CPU IRQ, active-low (registered).

Behaviour:
- Reset values: slv_datard_o=00, irqn_o=1, pb7_o=1, pb7_en_o=0.
- Reset values, internal: T1/T2 counters=FFFF, T1 latches=FFFF, T2 low latch=FF, ACR=00, IFR=00, IER=00, both timers disarmed.
- Tick: one clk6x pulse per phi2 falling edge, 2 clk6x (PHI2_SYNC=1) or 1 clk6x (PHI2_SYNC=0) after the edge.
- Reads: slv_datard_o updates every cycle with req & rwn.
  - Offsets 4/5: T1 counter lo/hi.
  - Offsets 6/7: T1 latch lo/hi.
  - Offsets 8/9: T2 counter lo/hi.
  - Offset B: ACR.
  - Offset D: IFR, bit7 = |(IFR[6:0] & IER[6:0]).
  - Offset E: IER, bit7 reads 1.
  - Other offsets read 00.
- Read side effects: fire in the single cycle where req & rwn rises.
  - Offset 4 clears IFR[6].
  - Offset 8 clears IFR[5].
- Writes: commit once per access, in the cycle where req & !rwn & datawr_valid rises.
  - 4/6: write T1 latch lo.
  - 5: write T1 latch hi, load counter = {data, latch lo}, clear IFR[6], arm T1, pb7_o=0 if ACR[7].
  - 7: write T1 latch hi, clear IFR[6].
  - 8: write T2 latch lo.
  - 9: load T2 counter = {data, latch lo}, clear IFR[5], arm T2.
  - B: write ACR.
  - D: clear IFR bits written as 1.
  - E: if data[7]=1 set IER bits written as 1, else clear them.
- T1 on tick:
  - Counter != 0: decrement.
  - Counter == 0 and armed: set IFR[6].
  - Counter == 0, ACR[6]=1 (free-run): reload from latches, stay armed, toggle pb7_o.
  - Counter == 0, ACR[6]=0 (one-shot): wrap to FFFF, disarm, pb7_o=1.
  - Counter == 0 and disarmed: wrap to FFFF, no flag.
  - Net effect: load N gives IFR[6] set on tick N+1.
- T2 on tick (phi2 mode): decrement; at 0 while armed, set IFR[5] and disarm. Always wraps 0 -> FFFF.
- Priority:
  - A write to a counter-high offset in the same cycle as a tick: the write wins, no decrement.
  - A flag set by a tick beats a read-clear or IFR write-clear in the same cycle.
- IRQ: irqn_o = ~|(IFR[6:0] & IER[6:0]), registered, 1 cycle after IFR/IER change.
- Reset asserted mid-count: immediate return to reset values. No tick is generated from the first phi2 edge after release.

Optional Feature:
- Macro VIA_T2_PULSECOUNT_EN.
- Defined: pb6_i passes through a 2-FF synchronizer. When ACR[5]=1, T2 decrements on each pb6 falling edge instead of the phi2 tick. Underflow and flag rules are unchanged.
- Undefined: ACR[5] is stored and readable but ignored. pb6_i is unused and T2 always counts phi2 ticks.

Decomposition:
- Shared package via_pkg holds:
  - Register offset constants REG_T1CL..REG_IER (4'h4..4'hE).
  - IFR bit indices: IFR_T2=5, IFR_T1=6, IFR_ANY=7.
  - ACR bit indices: ACR_T2_PULSE=5, ACR_T1_FREERUN=6, ACR_T1_PB7=7.
- One sub-module via_timer16, instantiated twice:
  - 16-bit down-counter with load, tick, armed flag and one-cycle underflow pulse.
  - Parameter FREERUN_CAPABLE; 0 for T2.

Test Plan:
- Reset then read D, E, B -> 00, 80, 00; irqn_o=1.
- Write E=C0, 4=05, 5=00 (one-shot) -> IFR[6] set on 6th tick, irqn_o=0; read 4 -> IFR[6]=0, irqn_o=1.
- ACR=40, T1 load 0003 -> IFR[6] set every 4 ticks. With ACR=C0, pb7_o goes 0 at load and toggles each underflow.
- Write 8=02, 9=00, IER=A0 -> IFR[5] on 3rd tick; no second flag after wrap to FFFF; write D=20 clears it.
- Write to offset 5 in the same cycle as a tick -> counter equals the loaded value, not loaded-1. Tick underflow coinciding with a read of offset 4 -> IFR[6] remains 1.
- VIA_T2_PULSECOUNT_EN: ACR=20, T2 load 0004 -> 5 pb6 falling edges set IFR[5]; phi2 ticks do not decrement T2.
